// File: rtl/text_video_pkg.sv
// text_video_pkg: raster timing presets, width helper and timing struct shared by the text video path
package text_video_pkg;
  typedef struct packed {
    int h_active, h_fp, h_sync, h_bp;
    int v_active, v_fp, v_sync, v_bp;
    bit hsync_pol, vsync_pol;
  } timing_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam timing_t VGA_640x480 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                      v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
                                      hsync_pol: 1'b0, vsync_pol: 1'b0};
  localparam timing_t SVGA_800x600 = '{h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
                                       v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
                                       hsync_pol: 1'b1, vsync_pol: 1'b1};
  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_HCNT_W = cw(VGA_H_TOTAL);
  localparam int VGA_VCNT_W = cw(VGA_V_TOTAL);
  localparam int SVGA_HCNT_W = cw(1056);
  localparam int SVGA_VCNT_W = cw(628);
endpackage

// File: rtl/video_sync_delay.sv
// video_sync_delay: WIDTH x DEPTH shift register with a reset value input; DEPTH=0 passes straight through
module video_sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = ^{clk, rst, i_rst_val};
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_sr [DEPTH];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_sr[i] <= i_rst_val;
      end else begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    assign o_q = r_sr[DEPTH-1];
  end
endmodule

// File: rtl/text_video_timing.sv
// text_video_timing: parametrised raster and character-cell timing for the text VRAM display path
module text_video_timing
  import text_video_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_640x480.h_active,
  parameter int H_FP         = VGA_640x480.h_fp,
  parameter int H_SYNC       = VGA_640x480.h_sync,
  parameter int H_BP         = VGA_640x480.h_bp,
  parameter int V_ACTIVE     = VGA_640x480.v_active,
  parameter int V_FP         = VGA_640x480.v_fp,
  parameter int V_SYNC       = VGA_640x480.v_sync,
  parameter int V_BP         = VGA_640x480.v_bp,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 8,
  parameter int COLS         = H_ACTIVE / CHAR_W,
  parameter int ROWS         = V_ACTIVE / CHAR_H,
  parameter int ADDR_WIDTH   = 13,
  parameter int PIPE_DELAY   = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  output logic                  active,
  output logic [cw(COLS)-1:0]   char_col,
  output logic [cw(ROWS)-1:0]   char_row,
  output logic [cw(CHAR_W)-1:0] glyph_x,
  output logic [cw(CHAR_H)-1:0] glyph_y,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  pixel_en,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  blink
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = cw(H_TOTAL);
  localparam int VW = cw(V_TOTAL);
  localparam int GXW = cw(CHAR_W);
  localparam int GYW = cw(CHAR_H);
  localparam int BW = cw(BLINK_FRAMES);
  localparam logic [GXW-1:0] GX_LAST = GXW'(CHAR_W - 1);
  localparam logic [GYW-1:0] GY_LAST = GYW'(CHAR_H - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);
  if (H_ACTIVE % CHAR_W != 0 || V_ACTIVE % CHAR_H != 0) begin : g_bad_cell
    $error("text_video_timing: active area is not a whole number of character cells");
  end
  if (longint'(COLS) * ROWS > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
    $error("text_video_timing: COLS*ROWS exceeds the VRAM address space");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("text_video_timing: BLINK_FRAMES must be at least 1");
  end
  // r_h/r_v name the position the output registers will present after the next edge
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic r_hs, r_vs, r_started;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [BW-1:0] r_bcnt;
  logic w_hl, w_act, w_hs, w_vs, w_ls, w_fs, w_vz, w_hact, w_line, w_new_row, w_btc;
  logic [GXW-1:0] w_gx;
  logic [GYW-1:0] w_gy;
  logic [cw(COLS)-1:0] w_col;
  logic [cw(ROWS)-1:0] w_row;
  logic [ADDR_WIDTH-1:0] w_base;
  always_comb begin
    w_hl = int'(r_h) == H_TOTAL - 1;
    w_hact = int'(r_h) < H_ACTIVE;
    w_act = w_hact && int'(r_v) < V_ACTIVE;
    w_hs = (int'(r_h) >= H_ACTIVE + H_FP && int'(r_h) < H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    w_vs = (int'(r_v) >= V_ACTIVE + V_FP && int'(r_v) < V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    w_ls = r_h == '0;
    w_vz = w_ls && r_v == '0;
    w_fs = w_vz && r_started;
    w_gx = w_ls ? '0 : w_hact ? (glyph_x == GX_LAST ? '0 : glyph_x + 1'b1) : glyph_x;
    w_col = w_ls ? '0 : (w_hact && glyph_x == GX_LAST) ? char_col + 1'b1 : char_col;
    w_line = w_ls && r_v != '0 && int'(r_v) < V_ACTIVE;
    w_new_row = w_line && glyph_y == GY_LAST;
    w_gy = w_vz ? '0 : w_line ? (glyph_y == GY_LAST ? '0 : glyph_y + 1'b1) : glyph_y;
    w_row = w_vz ? '0 : w_new_row ? char_row + 1'b1 : char_row;
    w_base = w_vz ? '0 : w_new_row ? r_base + ADDR_WIDTH'(COLS) : r_base;
    w_btc = w_fs && r_bcnt == B_LAST;
  end
  always_ff @(posedge pixel_clk or posedge rst)
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
      r_started <= 1'b0;
      r_hs <= ~HSYNC_POL;
      r_vs <= ~VSYNC_POL;
      r_base <= '0;
      r_bcnt <= '0;
      active <= 1'b0;
      glyph_x <= '0;
      glyph_y <= '0;
      char_col <= '0;
      char_row <= '0;
      vram_addr <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      blink <= 1'b0;
    end else begin
      r_h <= w_hl ? '0 : r_h + 1'b1;
      if (w_hl) r_v <= (int'(r_v) == V_TOTAL - 1) ? '0 : r_v + 1'b1;
      r_started <= 1'b1;
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_base <= w_base;
      active <= w_act;
      glyph_x <= w_gx;
      glyph_y <= w_gy;
      char_col <= w_col;
      char_row <= w_row;
      vram_addr <= w_base + ADDR_WIDTH'(w_col);
      line_start <= w_ls;
      frame_start <= w_fs;
      if (w_fs) begin
        r_bcnt <= w_btc ? '0 : r_bcnt + 1'b1;
        blink <= blink ^ w_btc;
      end
    end
  video_sync_delay #(.WIDTH(3), .DEPTH(PIPE_DELAY)) u_delay (
    .clk       (pixel_clk),
    .rst       (rst),
    .i_rst_val ({~HSYNC_POL, ~VSYNC_POL, 1'b0}),
    .i_d       ({r_hs, r_vs, active}),
    .o_q       ({hsync, vsync, pixel_en})
  );
endmodule

// File: tb/tb_text_video_timing.sv
// tb_text_video_timing: directed checks of default VGA, a scaled small raster and an 800x600 variant
module tb_text_video_timing;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;

  logic a_active, a_hsync, a_vsync, a_pe, a_ls, a_fs, a_blink;
  logic [6:0] a_col;
  logic [5:0] a_row;
  logic [2:0] a_gx, a_gy;
  logic [12:0] a_addr;
  logic b_active, b_hsync, b_vsync, b_pe, b_ls, b_fs, b_blink;
  logic [1:0] b_col, b_row;
  logic [2:0] b_gx, b_gy;
  logic [12:0] b_addr;
  logic c_active, c_hsync, c_vsync, c_pe, c_ls, c_fs, c_blink;
  logic [6:0] c_col;
  logic [5:0] c_row;
  logic [2:0] c_gx;
  logic [3:0] c_gy;
  logic [12:0] c_addr;

  text_video_timing u_a (
    .pixel_clk(clk), .rst(rst), .active(a_active), .char_col(a_col), .char_row(a_row),
    .glyph_x(a_gx), .glyph_y(a_gy), .vram_addr(a_addr), .hsync(a_hsync), .vsync(a_vsync),
    .pixel_en(a_pe), .line_start(a_ls), .frame_start(a_fs), .blink(a_blink));

  text_video_timing #(.H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(24), .V_FP(1),
    .V_SYNC(2), .V_BP(3), .BLINK_FRAMES(2)) u_b (
    .pixel_clk(clk), .rst(rst), .active(b_active), .char_col(b_col), .char_row(b_row),
    .glyph_x(b_gx), .glyph_y(b_gy), .vram_addr(b_addr), .hsync(b_hsync), .vsync(b_vsync),
    .pixel_en(b_pe), .line_start(b_ls), .frame_start(b_fs), .blink(b_blink));

  text_video_timing #(.H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88), .V_ACTIVE(600), .V_FP(1),
    .V_SYNC(4), .V_BP(23), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CHAR_H(12), .PIPE_DELAY(0)) u_c (
    .pixel_clk(clk), .rst(rst), .active(c_active), .char_col(c_col), .char_row(c_row),
    .glyph_x(c_gx), .glyph_y(c_gy), .vram_addr(c_addr), .hsync(c_hsync), .vsync(c_vsync),
    .pixel_en(c_pe), .line_start(c_ls), .frame_start(c_fs), .blink(c_blink));

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int a_fall = -1, a_nfall = 0, b_nfs = 0, b_fs_last = -10, b_vslow = 0, b_pe_cnt = 0, c_hhi = 0, a_lows = 0;
  bit a_hs_prev = 1'b1, a_per_done = 1'b0, a_wid_done = 1'b0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_hsync", a_hsync, 1);
    check("rst_a_vsync", a_vsync, 1);
    check("rst_a_active", a_active, 0);
    check("rst_a_pixel_en", a_pe, 0);
    check("rst_a_addr", a_addr, 0);
    check("rst_a_frame_start", a_fs, 0);
    check("rst_c_hsync", c_hsync, 0);
    check("rst_c_vsync", c_vsync, 0);
    rst = 1'b0;
    for (int c = 0; c <= 14700; c++) begin
      @(negedge clk);
      if (a_hs_prev && !a_hsync) begin
        a_nfall++;
        if (a_fall == -1) check("a_hs_first_low", c, 658);
        else if (!a_per_done) begin
          check("a_hs_period", c - a_fall, 800);
          a_per_done = 1'b1;
        end
        a_fall = c;
      end
      if (!a_hs_prev && a_hsync && !a_wid_done) begin
        check("a_hs_width", c - a_fall, 96);
        a_wid_done = 1'b1;
      end
      a_hs_prev = a_hsync;
      if (c == 0) begin
        check("a_first_active", a_active, 1);
        check("a_first_line_start", a_ls, 1);
        check("a_first_frame_start", a_fs, 0);
        check("a_first_addr", a_addr, 0);
      end
      if (c == 1) check("a_pe_lag1", a_pe, 0);
      if (c == 2) check("a_pe_lag2", a_pe, 1);
      if (c == 7) check("a_gx_h7", a_gx, 7);
      if (c == 8) begin
        check("a_gx_h8", a_gx, 0);
        check("a_col_h8", a_col, 1);
      end
      if (c == 639) begin
        check("a_addr_639_0", a_addr, 79);
        check("a_gx_639", a_gx, 7);
      end
      if (c == 641) check("a_pe_641", a_pe, 1);
      if (c == 642) check("a_pe_642", a_pe, 0);
      if (c == 700) begin
        check("a_active_blank", a_active, 0);
        check("a_addr_blank_hold", a_addr, 79);
      end
      if (c == 800) check("a_line_start_800", a_ls, 1);
      if (c == 5605) check("a_gy_line7", a_gy, 7);
      if (c == 6400) begin
        check("a_addr_0_8", a_addr, 80);
        check("a_row_0_8", a_row, 1);
        check("a_gy_0_8", a_gy, 0);
      end
      if (c < 1200 && !b_vsync) b_vslow++;
      if (c >= 1200 && c < 2400 && b_pe) b_pe_cnt++;
      if (c == 1199) check("b_vs_low_cycles", b_vslow, 80);
      if (c == 2399) check("b_pe_frame_cycles", b_pe_cnt, 768);
      if (c == 1001) check("b_vs_1001", b_vsync, 1);
      if (c == 1002) check("b_vs_1002", b_vsync, 0);
      if (c == 1081) check("b_vs_1081", b_vsync, 0);
      if (c == 1082) check("b_vs_1082", b_vsync, 1);
      if (c == 951) begin
        check("b_last_addr", b_addr, 11);
        check("b_last_gy", b_gy, 7);
      end
      if (b_fs) begin
        b_nfs++;
        if (b_nfs == 1) check("b_fs_first", c, 1200);
        else check("b_fs_gap", c - b_fs_last, 1200);
        b_fs_last = c;
      end
      if (c == b_fs_last + 1) check("b_blink", b_blink, (b_nfs / 2) % 2);
      if (c < 1056 && c_hsync) c_hhi++;
      if (c == 1055) begin
        check("c_hs_high_cycles", c_hhi, 128);
        check("c_ls_1055", c_ls, 0);
      end
      if (c == 1056) check("c_ls_1056", c_ls, 1);
      if (c == 839) check("c_hs_839", c_hsync, 0);
      if (c == 840) check("c_hs_840", c_hsync, 1);
      if (c == 967) check("c_hs_967", c_hsync, 1);
      if (c == 968) check("c_hs_968", c_hsync, 0);
      if (c == 500) check("c_vs_idle", c_vsync, 0);
      if (c == 799) check("c_addr_799_0", c_addr, 99);
      if (c == 800) check("c_active_800", c_active, 0);
      if (c == 11616) check("c_gy_line11", c_gy, 11);
      if (c == 12672) begin
        check("c_addr_0_12", c_addr, 100);
        check("c_gy_0_12", c_gy, 0);
      end
    end
    check("a_hs_fall_count", a_nfall, 18);
    check("b_fs_count", b_nfs, 12);
    rst = 1'b1;
    #1;
    check("mid_rst_active", a_active, 0);
    check("mid_rst_addr", a_addr, 0);
    check("mid_rst_col", a_col, 0);
    check("mid_rst_pe", a_pe, 0);
    check("mid_rst_hsync", a_hsync, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 700; c++) begin
      @(negedge clk);
      if (c < 658 && !a_hsync) a_lows++;
      if (c == 0) begin
        check("rel_active", a_active, 1);
        check("rel_addr", a_addr, 0);
        check("rel_line_start", a_ls, 1);
        check("rel_pe0", a_pe, 0);
      end
      if (c == 1) check("rel_pe1", a_pe, 0);
      if (c == 657) check("rel_hs_glitch_lows", a_lows, 0);
      if (c == 658) check("rel_hs_658", a_hsync, 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/text_video_timing.md
Name: text_video_timing

Overview:
Parametrised raster and character-cell timing generator for the text VRAM display path, superseding the fixed 640x480 sync logic inside text_vram_top.
- Generalises active and blanking geometry, sync polarity, and font cell width/height.
- Produces incremental character column/row, glyph pixel coordinates and a linear VRAM address, with no multipliers or dividers.
- Delays hsync/vsync/pixel_en by a configurable depth so they stay aligned with the VRAM and font-ROM read latency.
- Adds frame_start/line_start strobes and a cursor-blink phase.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync asserted level (0 = active-low)
VSYNC_POL, 0, vsync asserted level
CHAR_W, 8, glyph width in pixels
CHAR_H, 8, glyph height in lines
COLS, H_ACTIVE/CHAR_W, text columns
ROWS, V_ACTIVE/CHAR_H, text rows
ADDR_WIDTH, 13, VRAM address width
PIPE_DELAY, 2, pipeline stages for sync/pixel_en (0 = none)
BLINK_FRAMES, 32, frames per blink half-period

Ports:
pixel_clk  in  1  pixel clock; the only clock
rst  in  1  asynchronous, active-high reset
active  out  1  stage-0 visible-region flag
char_col  out  clog2(COLS)  stage-0 text column
char_row  out  clog2(ROWS)  stage-0 text row
glyph_x  out  clog2(CHAR_W)  pixel index within the cell
glyph_y  out  clog2(CHAR_H)  line index within the cell
vram_addr  out  ADDR_WIDTH  char_row*COLS + char_col
hsync  out  1  horizontal sync, delayed PIPE_DELAY cycles
vsync  out  1  vertical sync, delayed PIPE_DELAY cycles
pixel_en  out  1  active, delayed PIPE_DELAY cycles
line_start  out  1  1-cycle pulse at stage-0 h_cnt==0
frame_start  out  1  1-cycle pulse at stage-0 (h_cnt,v_cnt)==(0,0)
blink  out  1  cursor blink phase

Behaviour:
- Totals: H_TOTAL = sum of the four H_* values; V_TOTAL likewise for V_*.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1 to 0.
- Counter widths: clog2(H_TOTAL) and clog2(V_TOTAL).
- All outputs are registered.
- Stage 0 = the cycle in which the counters hold (h,v).
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - Raw hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Deasserted sync level = ~POL.
- Glyph/column tracking:
  - glyph_x increments on active pixels; at CHAR_W-1 it wraps to 0 and char_col increments.
  - Both return to 0 at h==0.
- Line tracking:
  - glyph_y increments at each line end inside V_ACTIVE; at CHAR_H-1 it wraps to 0 and char_row increments.
  - All return to 0 at v==0.
- vram_addr = row_base + char_col.
  - row_base += COLS when char_row increments; it clears at frame wrap.
  - No multiply is used.
  - During blanking, vram_addr/char_col/char_row hold their last values; only active is valid as a qualifier.
- hsync, vsync and pixel_en pass through a PIPE_DELAY-deep shift register.
  - Reset state of every stage: sync = ~POL, pixel_en = 0.
- line_start and frame_start are stage-0 aligned.
  - frame_start is suppressed for the first frame after reset release; line_start is not.
- Blink:
  - A frame counter increments on each frame_start.
  - On reaching BLINK_FRAMES-1 the counter clears and blink toggles.
- Reset values: counters, glyph/char/addr = 0; active = 0; hsync/vsync = ~POL; pixel_en, line_start, frame_start, blink = 0.
- First cycle after rst falls: stage 0 is (0,0) and active=1.
- Reset mid-frame: all state clears asynchronously, including the delay pipeline, and the raster restarts at (0,0). No partial sync pulse may be emitted after reset.
- Elaboration-time checks:
  - H_ACTIVE%CHAR_W==0 and V_ACTIVE%CHAR_H==0.
  - COLS*ROWS <= 2**ADDR_WIDTH.
  - BLINK_FRAMES >= 1.

Decomposition:
- Package text_video_pkg holds:
  - VGA_640x480 and SVGA_800x600 timing constants.
  - clog2-based width localparams.
  - A timing-struct typedef.
- One sub-module: video_sync_delay, a parameterised WIDTH x DEPTH shift register with async-reset value input. DEPTH=0 is a wire-through.

Test Plan:
1. Defaults, rst released: hsync=1 during reset; first low at cycle 656+2=658 after release, lasting 96 cycles; period 800 cycles.
2. vram_addr at pixel (639,0)=79; at (0,8)=80; at (639,479)=4799. glyph_y=7 on line 479; glyph_x=7 at h=7, 0 at h=8.
3. frame_start pulses exactly 420000 cycles apart, none in the first frame. vsync low on lines 490-491 only. pixel_en is high for exactly 307200 cycles per frame.
4. BLINK_FRAMES=2: blink toggles every 2nd frame_start (0→1 at the 2nd, 1→0 at the 4th).
5. rst asserted at (h=300,v=100) for 3 cycles: all outputs return to reset values immediately. After release, stage 0 = (0,0), vram_addr=0, and no sync glitch appears in the delayed outputs.
6. 800x600 (H 40/128/88, V 1/4/23), CHAR_H=12, POL=1, PIPE_DELAY=0:
   - COLS=100, ROWS=50; last active vram_addr=4999.
   - hsync high at h=840..967; totals 1056x628.
